// File: rtl/riscv_mem_stage_pkg.sv
// Shared widths, funct3 codes, FSM encoding and MEM-register payload for riscv_mem_stage.
package riscv_mem_stage_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned MEM_DATA_BUS = 32;
    localparam int unsigned REG_ADDR_W   = 5;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_BUS-1:0]    alu;
        logic [REG_BUS-1:0]    store_data;
        logic [2:0]            funct3;
        logic                  re;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
    } mem_entry_t;

    // Undefined funct3 codes fall back to a full-word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        case (funct3)
            LSU_B, LSU_BU: return SIZE_B;
            LSU_H, LSU_HU: return SIZE_H;
            LSU_W:         return SIZE_W;
            default:       return SIZE_W;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (lsu_size(funct3))
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte-lane placement for stores and lane extraction / extension for loads.
import riscv_mem_stage_pkg::*;

module riscv_lsu_align (
    input  logic [2:0]              funct3,
    input  logic [1:0]              addr_lo,
    input  logic [REG_BUS-1:0]      store_data,
    input  logic [MEM_DATA_BUS-1:0] rdata,
    output logic [3:0]              be,
    output logic [MEM_DATA_BUS-1:0] wdata,
    output logic [MEM_DATA_BUS-1:0] load_data
);

    logic [15:0] lane;
    logic        is_signed;

    always_comb begin
        lane      = 16'(rdata >> {addr_lo, 3'b000});
        is_signed = ~funct3[2];
        be        = 4'b0000;
        wdata     = '0;
        load_data = '0;
        case (lsu_size(funct3))
            SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & lane[7]}}, lane[7:0]};
            end
            // addr_lo == 3 leaves only the top byte enabled and the upper lane byte zero.
            SIZE_H: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{is_signed & lane[15]}}, lane[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: MEM pipeline stage; drives the data-memory bus and stalls EX while an access is open.
// Optional misaligned-access trap (misalign_o port) is enabled by defining RISCV_MISALIGN_TRAP_EN.
import riscv_mem_stage_pkg::*;

module riscv_mem_stage (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid_i,
    input  logic [REG_BUS-1:0]      ex_alu_i,
    input  logic [REG_BUS-1:0]      ex_store_i,
    input  logic [2:0]              ex_funct3_i,
    input  logic                    ex_re_i,
    input  logic                    ex_we_i,
    input  logic [REG_ADDR_W-1:0]   ex_rd_i,
    input  logic                    ex_reg_we_i,
    output logic                    stall_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [REG_BUS-1:0]      dmem_addr_o,
    output logic [3:0]              dmem_be_o,
    output logic [MEM_DATA_BUS-1:0] dmem_wdata_o,
    input  logic [MEM_DATA_BUS-1:0] dmem_rdata_i,
    input  logic                    dmem_ack_i,
    output logic [MEM_DATA_BUS-1:0] data_o,
    output logic [REG_BUS-1:0]      data_addr_o,
    output logic                    data_re_o,
    output logic                    data_we_o,
    output logic [REG_ADDR_W-1:0]   rd_o,
    output logic                    reg_we_o,
    output logic                    valid_o
`ifdef RISCV_MISALIGN_TRAP_EN
    ,
    output logic                    misalign_o
`endif
);

    mem_state_e              state_q;
    mem_state_e              state_d;
    mem_entry_t              mem_q;
    mem_entry_t              ex_entry;
    logic                    ex_mem_op;
    logic                    accept;
    logic                    complete;
    logic                    idle_reg_we;
    logic [3:0]              al_be;
    logic [MEM_DATA_BUS-1:0] al_wdata;
    logic [MEM_DATA_BUS-1:0] al_ldata;

    assign ex_entry = '{
        valid:      ex_valid_i,
        alu:        ex_alu_i,
        store_data: ex_store_i,
        funct3:     ex_funct3_i,
        re:         ex_re_i,
        we:         ex_we_i,
        rd:         ex_rd_i,
        reg_we:     ex_reg_we_i
    };

    // A misaligned access is retired straight from IDLE with the trap flag instead of going to memory.
`ifdef RISCV_MISALIGN_TRAP_EN
    logic mem_misalign;
    assign ex_mem_op    = ex_valid_i & (ex_re_i | ex_we_i)
                        & ~lsu_misaligned(ex_funct3_i, ex_alu_i[1:0]);
    assign mem_misalign = mem_q.valid & (mem_q.re | mem_q.we)
                        & lsu_misaligned(mem_q.funct3, mem_q.alu[1:0]);
    assign idle_reg_we  = mem_q.valid & mem_q.reg_we & ~mem_misalign;
`else
    assign ex_mem_op    = ex_valid_i & (ex_re_i | ex_we_i);
    assign idle_reg_we  = mem_q.valid & mem_q.reg_we;
`endif

    riscv_lsu_align u_align (
        .funct3     (mem_q.funct3),
        .addr_lo    (mem_q.alu[1:0]),
        .store_data (mem_q.store_data),
        .rdata      (dmem_rdata_i),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus drive and stall; a new EX entry is taken whenever the stage is not waiting on memory.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        complete     = 1'b0;
        stall_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        case (state_q)
            MEM_IDLE: begin
                accept = 1'b1;
            end
            MEM_BUSY: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = mem_q.we;
                dmem_addr_o  = {mem_q.alu[REG_BUS-1:2], 2'b00};
                dmem_be_o    = al_be;
                dmem_wdata_o = mem_q.we ? al_wdata : '0;
                stall_o      = ~dmem_ack_i;
                accept       = dmem_ack_i;
                complete     = dmem_ack_i;
            end
        endcase
        if (accept) begin
            state_d = ex_mem_op ? MEM_BUSY : MEM_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (accept) begin
            mem_q <= ex_entry;
        end
    end

    // WB register: bubble while waiting, memory result on ack, plain passthrough otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o     <= 1'b0;
            data_o      <= '0;
            data_addr_o <= '0;
            data_re_o   <= 1'b0;
            data_we_o   <= 1'b0;
            rd_o        <= '0;
            reg_we_o    <= 1'b0;
        end else if (!accept) begin
            valid_o     <= 1'b0;
            data_o      <= '0;
            data_addr_o <= '0;
            data_re_o   <= 1'b0;
            data_we_o   <= 1'b0;
            rd_o        <= '0;
            reg_we_o    <= 1'b0;
        end else if (complete) begin
            valid_o     <= mem_q.valid;
            data_o      <= mem_q.re ? al_ldata : '0;
            data_addr_o <= mem_q.alu;
            data_re_o   <= mem_q.re;
            data_we_o   <= mem_q.we;
            rd_o        <= mem_q.rd;
            reg_we_o    <= mem_q.valid & mem_q.reg_we;
        end else begin
            valid_o     <= mem_q.valid;
            data_o      <= '0;
            data_addr_o <= mem_q.alu;
            data_re_o   <= 1'b0;
            data_we_o   <= 1'b0;
            rd_o        <= mem_q.rd;
            reg_we_o    <= idle_reg_we;
        end
    end

`ifdef RISCV_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= accept & (state_q == MEM_IDLE) & mem_misalign;
        end
    end
`endif

endmodule
